dispatch_ctrl: RTL and testbench

//  Sits between the decoder and the three reservation stations (ALU, BRANCH, LSU).

---
 rtl/dispatch_pkg.sv | 44 ++++
 rtl/uop_fifo2.sv | 77 +++++++
 rtl/dispatch_ctrl.sv | 130 +++++++++++++
 tb/tb_dispatch_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// ---------------------------------------------------------------------------
// dispatch_pkg
//   Shared types and constants for the dispatch stage: the 65-bit decoded
//   micro-op layout, functional-unit selector codes, ALUOp encodings, and
//   queue geometry.
// ---------------------------------------------------------------------------
package dispatch_pkg;

    localparam int UOP_W = 65;
    localparam int DEPTH = 2;

    // Functional-unit selector carried in the micro-op.
    localparam logic [1:0] FU_ALU = 2'b00;
    localparam logic [1:0] FU_BR  = 2'b01;
    localparam logic [1:0] FU_LSU = 2'b10;
    localparam logic [1:0] FU_ILL = 2'b11;

    // ALUOp encodings produced by the decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address calc / plain add
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R-type, use funct fields
    localparam logic [1:0] ALUOP_IMM   = 2'b11;  // I-type arithmetic

    // MSB first: pc occupies bits [64:56], regwrite is bit 0.
    typedef struct packed {
        logic [8:0]  pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alusrc;
        logic        branch;
        logic [1:0]  aluop;
        logic [1:0]  futype;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
    } uop_t;

    function automatic logic [1:0] uop_fu(input uop_t u);
        return u.futype;
    endfunction

endpackage

// File: rtl/uop_fifo2.sv
// ---------------------------------------------------------------------------
// uop_fifo2
//   Two-entry register FIFO for decoded micro-ops. Head is read straight from
//   the storage registers, so an entry pushed in cycle N is visible on head_o
//   in cycle N+1.
// Ports
//   clk, reset  clock, synchronous active-high reset
//   clear_i     drop all entries (takes priority over push/pop)
//   push_i      write din_i (ignored when full)
//   pop_i       retire head (ignored when empty)
//   din_i       micro-op to enqueue
//   full_o      both entries occupied
//   empty_o     no entries occupied
//   head_o      oldest entry
// ---------------------------------------------------------------------------
module uop_fifo2
    import dispatch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic push_i,
    input  logic pop_i,
    input  uop_t din_i,
    output logic full_o,
    output logic empty_o,
    output uop_t head_o
);

    uop_t       mem_q [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push_en, pop_en;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i && !full_o && !clear_i;
    assign pop_en  = pop_i && !empty_o && !clear_i;

    // Payload registers carry no reset; occupancy is tracked by cnt_q.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_en && (wr_ptr_q == 1'(gi))) begin
                mem_q[gi] <= din_i;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en) wr_ptr_d = ~wr_ptr_q;
        if (pop_en)  rd_ptr_d = ~rd_ptr_q;
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// dispatch_ctrl
//   Buffers decoded micro-ops in a 2-entry in-order queue and steers the head
//   to the ALU, BRANCH or LSU reservation station by its FUtype. Branch
//   dispatch is throttled by an outstanding-branch count and each dispatched
//   branch gets a rolling tag. FUtype 11 heads are dropped with an illegal
//   pulse. Flush (and reset) empties everything.
// Ports
//   clk, reset              clock, synchronous active-high reset
//   flush                   squash queue, zero branch count and tag
//   dec_valid/dec_ready     decoder handshake (ready = queue not full)
//   dec_uop                 decoded micro-op in
//   disp_uop                head payload shared by all stations
//   alu_valid/alu_ready     ALU station handshake
//   br_valid/br_ready       BRANCH station handshake
//   br_tag                  tag of the branch currently offered
//   lsu_valid/lsu_ready     LSU station handshake
//   br_resolve              one branch resolved this cycle
//   illegal                 FUtype 11 head dropped this cycle
//   br_cnt                  outstanding branch count
// ---------------------------------------------------------------------------
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int MAX_BR = 4,
    localparam int TW    = (MAX_BR > 1) ? $clog2(MAX_BR) : 1,
    localparam int CW    = $clog2(MAX_BR + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  uop_t          dec_uop,
    output uop_t          disp_uop,
    output logic          alu_valid,
    input  logic          alu_ready,
    output logic          br_valid,
    input  logic          br_ready,
    output logic [TW-1:0] br_tag,
    output logic          lsu_valid,
    input  logic          lsu_ready,
    input  logic          br_resolve,
    output logic          illegal,
    output logic [CW-1:0] br_cnt
);

    logic          q_full, q_empty;
    uop_t          q_head;
    logic          kill;
    logic          push, pop;
    logic          is_alu, is_br, is_lsu, is_ill;
    logic          br_credit, br_fire, br_dec;
    logic [CW-1:0] br_cnt_q, br_cnt_d;
    logic [TW-1:0] br_tag_q, br_tag_d;

    // Reset and flush both squash: outputs are masked in that cycle so no
    // station can see a handshake that is about to be discarded.
    assign kill = reset || flush;

    // Ready depends on registered occupancy only; a pop in the same cycle does
    // not reopen a full queue.
    assign dec_ready = !q_full;
    assign push      = dec_valid && dec_ready;

    uop_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (dec_uop),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    assign disp_uop = q_head;

    assign is_alu = !q_empty && (uop_fu(q_head) == FU_ALU);
    assign is_br  = !q_empty && (uop_fu(q_head) == FU_BR);
    assign is_lsu = !q_empty && (uop_fu(q_head) == FU_LSU);
    assign is_ill = !q_empty && (uop_fu(q_head) == FU_ILL);

    // Credit check uses the registered count, so a resolve arriving this cycle
    // only frees a slot for the next cycle.
    assign br_credit = (br_cnt_q < CW'(MAX_BR));

    assign alu_valid = !kill && is_alu;
    assign br_valid  = !kill && is_br && br_credit;
    assign lsu_valid = !kill && is_lsu;
    assign illegal   = !kill && is_ill;

    assign br_fire = br_valid && br_ready;
    assign pop     = (alu_valid && alu_ready) || br_fire ||
                     (lsu_valid && lsu_ready) || illegal;

    // A resolve with nothing outstanding is dropped rather than underflowing.
    assign br_dec = br_resolve && (br_cnt_q != '0);

    always_comb begin
        br_cnt_d = br_cnt_q;
        if (br_fire && !br_dec) begin
            br_cnt_d = br_cnt_q + CW'(1);
        end else if (!br_fire && br_dec) begin
            br_cnt_d = br_cnt_q - CW'(1);
        end
    end

    always_comb begin
        br_tag_d = br_tag_q;
        if (br_fire) begin
            br_tag_d = (br_tag_q == TW'(MAX_BR - 1)) ? '0 : br_tag_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            br_cnt_q <= '0;
            br_tag_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            br_tag_q <= br_tag_d;
        end
    end

    assign br_cnt = br_cnt_q;
    assign br_tag = br_tag_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
    import dispatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic       dec_valid, dec_ready;
    uop_t       dec_uop, disp_uop;
    logic       alu_valid, alu_ready;
    logic       br_valid, br_ready;
    logic [1:0] br_tag;
    logic       lsu_valid, lsu_ready;
    logic       br_resolve, illegal;
    logic [2:0] br_cnt;

    int tests_run = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    dispatch_ctrl #(.MAX_BR(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_uop    (dec_uop),
        .disp_uop   (disp_uop),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_tag     (br_tag),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .br_resolve (br_resolve),
        .illegal    (illegal),
        .br_cnt     (br_cnt)
    );

    // One line per accepted transaction.
    always @(posedge clk) begin
        if (dec_valid && dec_ready && !reset && !flush)
            $display("[TB] t=%0t enqueue pc=%h fu=%b", $time, dec_uop.pc, dec_uop.futype);
        if (alu_valid && alu_ready) $display("[TB] t=%0t dispatch ALU pc=%h", $time, disp_uop.pc);
        if (br_valid && br_ready)   $display("[TB] t=%0t dispatch BR pc=%h tag=%0d", $time, disp_uop.pc, br_tag);
        if (lsu_valid && lsu_ready) $display("[TB] t=%0t dispatch LSU pc=%h", $time, disp_uop.pc);
        if (illegal)                $display("[TB] t=%0t drop illegal pc=%h", $time, disp_uop.pc);
    end

    function automatic uop_t mk(input logic [8:0] pc, input logic [1:0] fu, input logic [4:0] rd);
        uop_t u;
        u          = '0;
        u.pc       = pc;
        u.rs1      = 5'd5;
        u.rs2      = 5'd6;
        u.rd       = rd;
        u.imm      = 32'h0000_0010;
        u.futype   = fu;
        u.aluop    = (fu == FU_BR) ? ALUOP_SUB : (fu == FU_LSU) ? ALUOP_ADD : ALUOP_FUNCT;
        u.branch   = (fu == FU_BR);
        u.memread  = (fu == FU_LSU) && (rd != 5'd0);
        u.memwrite = (fu == FU_LSU) && (rd == 5'd0);
        u.regwrite = (fu == FU_ALU);
        return u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_uop = '0;
        alu_ready = 1'b0; br_ready = 1'b0; lsu_ready = 1'b0; br_resolve = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        tests_run++; if (dec_ready !== 1'b1) begin fail_cnt++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready); end
        tests_run++; if ({alu_valid, br_valid, lsu_valid, illegal} !== 4'b0000) begin fail_cnt++; $display("FAIL reset_valids got=%b exp=0000", {alu_valid, br_valid, lsu_valid, illegal}); end
        tests_run++; if (br_cnt !== 3'd0) begin fail_cnt++; $display("FAIL reset_br_cnt got=%0d exp=0", br_cnt); end
        tests_run++; if (br_tag !== 2'd0) begin fail_cnt++; $display("FAIL reset_br_tag got=%0d exp=0", br_tag); end
    endtask

    task automatic test_alu();
        alu_ready = 1'b1;
        dec_valid = 1'b1; dec_uop = mk(9'h010, FU_ALU, 5'd1);
        #1;
        tests_run++; if (alu_valid !== 1'b0) begin fail_cnt++; $display("FAIL alu_same_cycle got=%b exp=0", alu_valid); end
        tick();
        // back-to-back: second ADD enqueued while the first dispatches
        dec_uop = mk(9'h014, FU_ALU, 5'd7);
        #1;
        tests_run++; if (alu_valid !== 1'b1) begin fail_cnt++; $display("FAIL alu_valid got=%b exp=1", alu_valid); end
        tests_run++; if (disp_uop.rd !== 5'd1) begin fail_cnt++; $display("FAIL alu_rd got=%0d exp=1", disp_uop.rd); end
        tests_run++; if (disp_uop.pc !== 9'h010) begin fail_cnt++; $display("FAIL alu_pc got=%h exp=010", disp_uop.pc); end
        tick();
        dec_valid = 1'b0;
        #1;
        tests_run++; if (disp_uop.pc !== 9'h014 || alu_valid !== 1'b1) begin fail_cnt++; $display("FAIL alu_b2b got pc=%h v=%b exp pc=014 v=1", disp_uop.pc, alu_valid); end
        tick();
        #1;
        tests_run++; if (alu_valid !== 1'b0 || dec_ready !== 1'b1) begin fail_cnt++; $display("FAIL alu_drain got v=%b rdy=%b exp v=0 rdy=1", alu_valid, dec_ready); end
        alu_ready = 1'b0;
    endtask

    task automatic test_lsu_order();
        lsu_ready = 1'b0;
        dec_valid = 1'b1; dec_uop = mk(9'h020, FU_LSU, 5'd2);
        tick();
        dec_uop = mk(9'h024, FU_LSU, 5'd0);
        tick();
        dec_valid = 1'b0;
        #1;
        tests_run++; if (dec_ready !== 1'b0) begin fail_cnt++; $display("FAIL lsu_full_ready got=%b exp=0", dec_ready); end
        tests_run++; if (lsu_valid !== 1'b1 || disp_uop.pc !== 9'h020) begin fail_cnt++; $display("FAIL lsu_head got v=%b pc=%h exp v=1 pc=020", lsu_valid, disp_uop.pc); end
        tick();
        #1;
        tests_run++; if (disp_uop.pc !== 9'h020 || alu_valid !== 1'b0 || br_valid !== 1'b0) begin fail_cnt++; $display("FAIL lsu_hold got pc=%h exp=020", disp_uop.pc); end
        lsu_ready = 1'b1;
        #1;
        tests_run++; if (dec_ready !== 1'b0) begin fail_cnt++; $display("FAIL lsu_no_bypass got=%b exp=0", dec_ready); end
        tick();
        #1;
        tests_run++; if (lsu_valid !== 1'b1 || disp_uop.pc !== 9'h024 || disp_uop.memwrite !== 1'b1) begin fail_cnt++; $display("FAIL lsu_second got v=%b pc=%h exp v=1 pc=024", lsu_valid, disp_uop.pc); end
        tests_run++; if (dec_ready !== 1'b1) begin fail_cnt++; $display("FAIL lsu_ready_after got=%b exp=1", dec_ready); end
        tick();
        #1;
        tests_run++; if (lsu_valid !== 1'b0) begin fail_cnt++; $display("FAIL lsu_empty got=%b exp=0", lsu_valid); end
        lsu_ready = 1'b0;
    endtask

    task automatic test_branch_credit();
        br_ready = 1'b1; br_resolve = 1'b0;
        dec_valid = 1'b1; dec_uop = mk(9'h100, FU_BR, 5'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            dec_uop = mk(9'(9'h100 + 4 * i), FU_BR, 5'd0);
            #1;
            tests_run++;
            if (br_valid !== 1'b1 || br_tag !== 2'(i - 1) || br_cnt !== 3'(i - 1) || disp_uop.pc !== 9'(9'h100 + 4 * (i - 1))) begin
                fail_cnt++;
                $display("FAIL br_seq%0d got v=%b tag=%0d cnt=%0d pc=%h exp v=1 tag=%0d cnt=%0d", i, br_valid, br_tag, br_cnt, disp_uop.pc, i - 1, i - 1);
            end
            tick();
        end
        dec_valid = 1'b0;
        #1;
        tests_run++; if (br_valid !== 1'b0 || br_cnt !== 3'd4 || br_tag !== 2'd0) begin fail_cnt++; $display("FAIL br_stall got v=%b cnt=%0d tag=%0d exp v=0 cnt=4 tag=0", br_valid, br_cnt, br_tag); end
        tick();
        br_resolve = 1'b1;
        #1;
        tests_run++; if (br_valid !== 1'b0) begin fail_cnt++; $display("FAIL br_resolve_registered got=%b exp=0", br_valid); end
        tick();
        br_resolve = 1'b0;
        #1;
        tests_run++; if (br_valid !== 1'b1 || br_tag !== 2'd0 || disp_uop.pc !== 9'h110) begin fail_cnt++; $display("FAIL br_fifth got v=%b tag=%0d pc=%h exp v=1 tag=0 pc=110", br_valid, br_tag, disp_uop.pc); end
        tick();
        #1;
        tests_run++; if (br_cnt !== 3'd4 || br_valid !== 1'b0 || br_tag !== 2'd1) begin fail_cnt++; $display("FAIL br_after_fifth got cnt=%0d tag=%0d exp cnt=4 tag=1", br_cnt, br_tag); end
    endtask

    task automatic test_branch_net_zero();
        br_resolve = 1'b1;
        tick(); tick();
        br_resolve = 1'b0;
        #1;
        tests_run++; if (br_cnt !== 3'd2) begin fail_cnt++; $display("FAIL br_drain got=%0d exp=2", br_cnt); end
        dec_valid = 1'b1; dec_uop = mk(9'h120, FU_BR, 5'd0);
        tick();
        dec_valid = 1'b0; br_resolve = 1'b1;
        #1;
        tests_run++; if (br_valid !== 1'b1 || br_tag !== 2'd1) begin fail_cnt++; $display("FAIL br_nz_offer got v=%b tag=%0d exp v=1 tag=1", br_valid, br_tag); end
        tick();
        br_resolve = 1'b0;
        #1;
        tests_run++; if (br_cnt !== 3'd2 || br_tag !== 2'd2) begin fail_cnt++; $display("FAIL br_net_zero got cnt=%0d tag=%0d exp cnt=2 tag=2", br_cnt, br_tag); end
    endtask

    task automatic test_illegal();
        alu_ready = 1'b0;
        dec_valid = 1'b1; dec_uop = mk(9'h030, FU_ILL, 5'd3);
        tick();
        dec_uop = mk(9'h040, FU_ALU, 5'd4);
        #1;
        tests_run++; if (illegal !== 1'b1 || {alu_valid, br_valid, lsu_valid} !== 3'b000) begin fail_cnt++; $display("FAIL ill_pulse got ill=%b v=%b exp ill=1 v=000", illegal, {alu_valid, br_valid, lsu_valid}); end
        tick();
        dec_valid = 1'b0;
        #1;
        tests_run++; if (illegal !== 1'b0 || alu_valid !== 1'b1 || disp_uop.pc !== 9'h040) begin fail_cnt++; $display("FAIL ill_advance got ill=%b alu=%b pc=%h exp ill=0 alu=1 pc=040", illegal, alu_valid, disp_uop.pc); end
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
    endtask

    task automatic test_flush();
        lsu_ready = 1'b0;
        dec_valid = 1'b1; dec_uop = mk(9'h050, FU_LSU, 5'd8);
        tick();
        dec_uop = mk(9'h054, FU_LSU, 5'd9);
        tick();
        dec_uop = mk(9'h058, FU_ALU, 5'd10);
        flush = 1'b1; lsu_ready = 1'b1; br_resolve = 1'b1; alu_ready = 1'b1;
        #1;
        tests_run++; if (dec_ready !== 1'b0 || lsu_valid !== 1'b0) begin fail_cnt++; $display("FAIL flush_cycle got rdy=%b lsu=%b exp rdy=0 lsu=0", dec_ready, lsu_valid); end
        tick();
        flush = 1'b0; dec_valid = 1'b0; br_resolve = 1'b0;
        #1;
        tests_run++; if (dec_ready !== 1'b1 || br_cnt !== 3'd0 || br_tag !== 2'd0) begin fail_cnt++; $display("FAIL flush_state got rdy=%b cnt=%0d tag=%0d exp rdy=1 cnt=0 tag=0", dec_ready, br_cnt, br_tag); end
        tests_run++; if ({alu_valid, br_valid, lsu_valid, illegal} !== 4'b0000) begin fail_cnt++; $display("FAIL flush_valids got=%b exp=0000", {alu_valid, br_valid, lsu_valid, illegal}); end
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        #1;
        tests_run++; if (br_cnt !== 3'd0) begin fail_cnt++; $display("FAIL resolve_at_zero got=%0d exp=0", br_cnt); end
        alu_ready = 1'b0; lsu_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        dec_valid = 1'b1; dec_uop = mk(9'h060, FU_ILL, 5'd1);
        tick();
        dec_valid = 1'b0; reset = 1'b1;
        #1;
        tests_run++; if (illegal !== 1'b0) begin fail_cnt++; $display("FAIL reset_mid_illegal got=%b exp=0", illegal); end
        tick();
        reset = 1'b0;
        #1;
        tests_run++; if (illegal !== 1'b0 || dec_ready !== 1'b1 || br_cnt !== 3'd0) begin fail_cnt++; $display("FAIL reset_mid_state got ill=%b rdy=%b cnt=%0d exp 0 1 0", illegal, dec_ready, br_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_lsu_order();
        test_branch_credit();
        test_branch_net_zero();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
